// File: rtl/flopwb_pkg.sv
// flopwb_pkg: shared pipeline widths for the MEM/WB stage register
package flopwb_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int REGADDR_WIDTH = 4;
endpackage

// File: rtl/flopwb_flopr.sv
// flopr: generic register with synchronous active-high clear
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk)
        q <= reset ? '0 : d;
endmodule

// File: rtl/flopwb.sv
// flopwb: MEM/WB pipeline register, controls and data captured as one bundle
module flopwb
    import flopwb_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     PCSrcM,
    input  logic                     RegWriteM,
    input  logic                     MemtoRegM,
    input  logic [REGADDR_WIDTH-1:0] WA3M,
    input  logic [WIDTH-1:0]         ALUOutM,
    input  logic [WIDTH-1:0]         ReadDataM,
    output logic [WIDTH-1:0]         ReadDataW,
    output logic [WIDTH-1:0]         ALUOutW,
    output logic                     PCSrcW,
    output logic                     RegWriteW,
    output logic                     MemtoRegW,
    output logic [REGADDR_WIDTH-1:0] WA3W
);
    localparam int BW = 3 + REGADDR_WIDTH + 2 * WIDTH;
    flopr #(.WIDTH(BW)) r (
        .clk(clk),
        .reset(reset),
        .d({PCSrcM, RegWriteM, MemtoRegM, WA3M, ALUOutM, ReadDataM}),
        .q({PCSrcW, RegWriteW, MemtoRegW, WA3W, ALUOutW, ReadDataW})
    );
endmodule

// File: tb/tb_flopwb.sv
// tb_flopwb: randomized checks of flopwb against a one-deep pipeline model
module tb_flopwb;
    typedef struct packed {
        logic        pc;
        logic        rw;
        logic        mr;
        logic [3:0]  wa;
        logic [31:0] alu;
        logic [31:0] rd;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    vec_t din = '0;
    vec_t exp_v = '0;
    vec_t hist[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] rdw, aluw;
    logic [3:0] waw;
    logic pcw, rww, mrw;
    always #5 clk = ~clk;
    flopwb #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .PCSrcM(din.pc), .RegWriteM(din.rw), .MemtoRegM(din.mr), .WA3M(din.wa),
        .ALUOutM(din.alu), .ReadDataM(din.rd),
        .ReadDataW(rdw), .ALUOutW(aluw), .PCSrcW(pcw), .RegWriteW(rww),
        .MemtoRegW(mrw), .WA3W(waw)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask
    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".PCSrcW"}, 32'(pcw), 32'(e.pc));
        chk({tag, ".RegWriteW"}, 32'(rww), 32'(e.rw));
        chk({tag, ".MemtoRegW"}, 32'(mrw), 32'(e.mr));
        chk({tag, ".WA3W"}, 32'(waw), 32'(e.wa));
        chk({tag, ".ALUOutW"}, aluw, e.alu);
        chk({tag, ".ReadDataW"}, rdw, e.rd);
    endtask
    function automatic vec_t rand_vec();
        vec_t v;
        v.pc = 1'($urandom);
        v.rw = 1'($urandom);
        v.mr = 1'($urandom);
        v.wa = 4'($urandom);
        v.alu = $urandom;
        v.rd = $urandom;
        return v;
    endfunction
    // Drive one vector for an edge; the model says W equals the edge's M, or zero under reset.
    task automatic cycle(input string tag, input vec_t v, input logic r);
        @(negedge clk);
        din = v;
        reset = r;
        hist.push_back(r ? vec_t'('0) : v);
        @(posedge clk);
        #1;
        exp_v = hist.pop_front();
        chk_all(tag, exp_v);
    endtask
    // Disturb inputs and reset between edges; outputs must not move.
    task automatic disturb(input string tag);
        #1;
        din = rand_vec();
        reset = 1'b1;
        #2;
        chk_all(tag, exp_v);
    endtask
    initial begin
        vec_t v;
        cycle("rst0", rand_vec(), 1'b1);
        cycle("rst1", rand_vec(), 1'b1);
        v = '{pc: 1'b1, rw: 1'b1, mr: 1'b0, wa: 4'hA, alu: 32'h0000_0005, rd: 32'hDEAD_BEEF};
        cycle("first", v, 1'b0);
        for (int i = 0; i < 5; i++) cycle($sformatf("stream%0d", i), rand_vec(), 1'b0);
        cycle("ones", '1, 1'b0);
        cycle("zeros", '0, 1'b0);
        cycle("ones2", '1, 1'b0);
        cycle("hold_pre", rand_vec(), 1'b0);
        disturb("hold");
        cycle("mid_a", rand_vec(), 1'b0);
        v = rand_vec();
        v.wa = 4'h7;
        v.pc = 1'b1;
        cycle("mid_rst", v, 1'b1);
        cycle("mid_after", rand_vec(), 1'b0);
        for (int i = 0; i < 200; i++) begin
            cycle($sformatf("rnd%0d", i), rand_vec(), ($urandom % 8) == 0);
            if ((i % 17) == 5) disturb($sformatf("rnd_hold%0d", i));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/flopwb.md
FLOPWB -- requirements
Module: flopwb

Interface
REQ-001 Parameter WIDTH, default 32, data-path width of ALU result and memory read data.
REQ-002 The block SHALL have one clock and synchronous, active-high reset; ports are named clk and reset.
REQ-003 Port order, which is positional and fixed, SHALL be exactly as listed in REQ-004 to REQ-017.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 PCSrcM  input  1  PC-source control from MEM stage.
REQ-007 RegWriteM  input  1  register-file write enable from MEM stage.
REQ-008 MemtoRegM  input  1  writeback select (1 = memory data, 0 = ALU result).
REQ-009 WA3M  input  4  destination register address.
REQ-010 ALUOutM  input  WIDTH  ALU result.
REQ-011 ReadDataM  input  WIDTH  data-memory read data.
REQ-012 ReadDataW  output  WIDTH  registered ReadDataM.
REQ-013 ALUOutW  output  WIDTH  registered ALUOutM.
REQ-014 PCSrcW  output  1  registered PCSrcM.
REQ-015 RegWriteW  output  1  registered RegWriteM.
REQ-016 MemtoRegW  output  1  registered MemtoRegM.
REQ-017 WA3W  output  4  registered WA3M; this port is last so that a 13-port positional hookup leaves only WA3W unconnected.

Function
REQ-018 The block SHALL be a MEM/WB pipeline register: on each rising clk edge with reset low, every W output SHALL take the value its M input had at that edge.
REQ-019 Latency SHALL be exactly one clock cycle, with no combinational path from any input to any output.
REQ-020 Outputs SHALL hold their value between clock edges regardless of input changes.
REQ-021 All fields SHALL update together on the same edge, with no enable, stall or flush; every cycle is a load.
REQ-022 Data SHALL pass unmodified: no sign extension, truncation or arithmetic, and all WIDTH bits are preserved, including all-ones and all-zeros patterns.
REQ-023 An X or Z on an input SHALL propagate only to its own output field, with no cross-field corruption.

Reset
REQ-024 When reset is high at a rising clk edge, all outputs SHALL become 0 on that edge: ReadDataW, ALUOutW, PCSrcW, RegWriteW, MemtoRegW and WA3W.
REQ-025 Reset SHALL have priority over data capture, so inputs are ignored on reset edges.
REQ-026 Asserting reset between edges SHALL NOT change outputs until the next rising edge, because reset is synchronous.
REQ-027 On the first edge after reset deasserts, outputs SHALL capture the inputs present at that edge.
REQ-028 Reset asserted mid-stream SHALL clear outputs on the next edge, and outputs SHALL resume capturing on the first edge with reset low.

Structure
REQ-029 A shared pipeline package SHALL hold the default WIDTH (32) and the register-address width constant (4).
REQ-030 A single generic sub-module flopr (parameter WIDTH; ports clk, reset, d, q; synchronous active-high reset to 0) SHALL be used, instantiated once per field or once for a concatenated control+data bundle.
REQ-031 The block SHALL contain no other logic and SHALL be fully synthesizable.

Verification
In the scenarios below, outputs are listed in the order {PCSrcW, RegWriteW, MemtoRegW, WA3W, ALUOutW, ReadDataW}.
REQ-032 Hold reset high for 2 edges with arbitrary inputs -> all outputs read 0.
REQ-033 Release reset; drive PCSrcM=1, RegWriteM=1, MemtoRegM=0, WA3M=4'hA, ALUOutM=32'h0000_0005, ReadDataM=32'hDEAD_BEEF -> after one edge, outputs equal {1,1,0,A,00000005,DEADBEEF}.
REQ-034 Stream 5 distinct vectors on consecutive edges -> each output vector equals the previous edge's input vector, with no skips or duplicates.
REQ-035 Drive all-ones (WA3M=4'hF, both data 32'hFFFF_FFFF, all controls 1) and then all-zeros -> outputs follow exactly one cycle later, with all bits intact.
REQ-036 Change inputs mid-cycle (between edges) -> outputs remain unchanged until the next rising edge.
REQ-037 Assert reset for one edge in the middle of a stream with inputs nonzero -> outputs read 0 for that cycle, then show the following vector one edge after reset drops.
